trace_dispatcher: RTL and testbench

Parametrised, buffered command dispatcher between the trace-file parser and the L2 cache model. It accepts decoded trace records (command, address) over a valid/ready handshake, queues them in a FIFO, and issues each record in order on one of three handshaked channels: L1 request, snoop request, or cache control. Illegal commands are dropped and flagged, and per-channel statistics counters are kept.

---
 rtl/trace_dispatcher.sv | 205 ++++++++++++++++++++
 tb/tb_trace_dispatcher.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_dispatcher.sv
// Trace record FIFO feeding one of three handshaked channels (L1, snoop, control) in order.
// Two edges from accept to channel valid; rec_ready drops when the queue is full, channels hold until ready.
module trace_dispatcher #(
  parameter int ADDR_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rec_valid,
  output logic                          rec_ready,
  input  logic [3:0]                    rec_cmd,
  input  logic [ADDR_WIDTH-1:0]         rec_addr,
  output logic                          l1_valid,
  input  logic                          l1_ready,
  output logic [1:0]                    l1_op,
  output logic [ADDR_WIDTH-1:0]         l1_addr,
  output logic                          snp_valid,
  input  logic                          snp_ready,
  output logic [1:0]                    snp_op,
  output logic [ADDR_WIDTH-1:0]         snp_addr,
  output logic                          ctl_valid,
  input  logic                          ctl_ready,
  output logic                          ctl_op,
  output logic                          err_cmd,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [CNT_WIDTH-1:0]          cnt_l1,
  output logic [CNT_WIDTH-1:0]          cnt_snp,
  output logic [CNT_WIDTH-1:0]          cnt_ctl,
  output logic [CNT_WIDTH-1:0]          cnt_err
);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int PW1 = PW + 1;
  localparam logic [PW-1:0]        PTR_ONE = PW'(1);
  localparam logic [PW:0]          OCC_ONE = PW1'(1);
  localparam logic [PW:0]          OCC_MAX = PW1'(FIFO_DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t state_q, state_d;
  logic [3:0]            cmd_mem  [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] addr_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic                  l1_valid_q, l1_valid_d, snp_valid_q, snp_valid_d, ctl_valid_q, ctl_valid_d;
  logic [1:0]            l1_op_q, l1_op_d, snp_op_q, snp_op_d;
  logic                  ctl_op_q, ctl_op_d, err_q, err_d;
  logic [ADDR_WIDTH-1:0] l1_addr_q, l1_addr_d, snp_addr_q, snp_addr_d;
  logic [CNT_WIDTH-1:0]  cnt_l1_q, cnt_l1_d, cnt_snp_q, cnt_snp_d;
  logic [CNT_WIDTH-1:0]  cnt_ctl_q, cnt_ctl_d, cnt_err_q, cnt_err_d;

  logic                  push, pop, hs, clr, head_legal;
  logic [1:0]            head_chan, head_op;
  logic [3:0]            head_cmd;
  logic [ADDR_WIDTH-1:0] head_addr;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  assign rec_ready = (count_q != OCC_MAX) && !reset;
  assign push      = rec_valid && rec_ready;
  assign hs        = (l1_valid_q && l1_ready) || (snp_valid_q && snp_ready) || (ctl_valid_q && ctl_ready);
  assign clr       = ctl_valid_q && ctl_ready && !ctl_op_q;
  // The head is only consumed when no channel is occupied or the occupant retires this edge.
  assign pop       = (count_q != '0) && ((state_q == IDLE) || hs);

  always_comb begin
    head_cmd   = cmd_mem[rd_ptr_q];
    head_addr  = addr_mem[rd_ptr_q];
    head_legal = 1'b1;
    head_chan  = 2'd0;
    head_op    = 2'd0;
    case (head_cmd)
      4'd0, 4'd1, 4'd2:       head_op = head_cmd[1:0];
      4'd3, 4'd4, 4'd5, 4'd6: begin head_chan = 2'd1; head_op = 2'(head_cmd - 4'd3); end
      4'd8, 4'd9:             begin head_chan = 2'd2; head_op = {1'b0, head_cmd[0]}; end
      default:                head_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d     = count_q;
    l1_valid_d  = l1_valid_q;
    l1_op_d     = l1_op_q;
    l1_addr_d   = l1_addr_q;
    snp_valid_d = snp_valid_q;
    snp_op_d    = snp_op_q;
    snp_addr_d  = snp_addr_q;
    ctl_valid_d = ctl_valid_q;
    ctl_op_d    = ctl_op_q;
    err_d       = 1'b0;
    cnt_l1_d    = cnt_l1_q;
    cnt_snp_d   = cnt_snp_q;
    cnt_ctl_d   = cnt_ctl_q;
    cnt_err_d   = cnt_err_q;

    if (push && !pop)      count_d = count_q + OCC_ONE;
    else if (pop && !push) count_d = count_q - OCC_ONE;

    if (l1_valid_q && l1_ready)   cnt_l1_d  = sat_inc(cnt_l1_q);
    if (snp_valid_q && snp_ready) cnt_snp_d = sat_inc(cnt_snp_q);
    if (ctl_valid_q && ctl_ready) cnt_ctl_d = sat_inc(cnt_ctl_q);

    if (hs) begin
      state_d     = IDLE;
      l1_valid_d  = 1'b0;
      l1_op_d     = '0;
      l1_addr_d   = '0;
      snp_valid_d = 1'b0;
      snp_op_d    = '0;
      snp_addr_d  = '0;
      ctl_valid_d = 1'b0;
      ctl_op_d    = 1'b0;
    end

    if (pop) begin
      if (head_legal) begin
        state_d = BUSY;
        case (head_chan)
          2'd0:    begin l1_valid_d  = 1'b1; l1_op_d  = head_op; l1_addr_d  = head_addr; end
          2'd1:    begin snp_valid_d = 1'b1; snp_op_d = head_op; snp_addr_d = head_addr; end
          default: begin ctl_valid_d = 1'b1; ctl_op_d = head_op[0]; end
        endcase
      end else begin
        err_d     = 1'b1;
        cnt_err_d = sat_inc(cnt_err_q);
      end
    end

    // A completed clear wins over every increment on the same edge.
    if (clr) begin
      cnt_l1_d  = '0;
      cnt_snp_d = '0;
      cnt_ctl_d = '0;
      cnt_err_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      cmd_mem[wr_ptr_q]  <= rec_cmd;
      addr_mem[wr_ptr_q] <= rec_addr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      l1_valid_q  <= 1'b0;
      l1_op_q     <= '0;
      l1_addr_q   <= '0;
      snp_valid_q <= 1'b0;
      snp_op_q    <= '0;
      snp_addr_q  <= '0;
      ctl_valid_q <= 1'b0;
      ctl_op_q    <= 1'b0;
      err_q       <= 1'b0;
      cnt_l1_q    <= '0;
      cnt_snp_q   <= '0;
      cnt_ctl_q   <= '0;
      cnt_err_q   <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      l1_valid_q  <= l1_valid_d;
      l1_op_q     <= l1_op_d;
      l1_addr_q   <= l1_addr_d;
      snp_valid_q <= snp_valid_d;
      snp_op_q    <= snp_op_d;
      snp_addr_q  <= snp_addr_d;
      ctl_valid_q <= ctl_valid_d;
      ctl_op_q    <= ctl_op_d;
      err_q       <= err_d;
      cnt_l1_q    <= cnt_l1_d;
      cnt_snp_q   <= cnt_snp_d;
      cnt_ctl_q   <= cnt_ctl_d;
      cnt_err_q   <= cnt_err_d;
    end
  end

  assign l1_valid   = l1_valid_q;
  assign l1_op      = l1_op_q;
  assign l1_addr    = l1_addr_q;
  assign snp_valid  = snp_valid_q;
  assign snp_op     = snp_op_q;
  assign snp_addr   = snp_addr_q;
  assign ctl_valid  = ctl_valid_q;
  assign ctl_op     = ctl_op_q;
  assign err_cmd    = err_q;
  assign fifo_count = count_q;
  assign cnt_l1     = cnt_l1_q;
  assign cnt_snp    = cnt_snp_q;
  assign cnt_ctl    = cnt_ctl_q;
  assign cnt_err    = cnt_err_q;
endmodule

// File: tb/tb_trace_dispatcher.sv
// Bench for trace_dispatcher: queue-based reference model plus directed and random scenarios.
module tb_trace_dispatcher;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rec_valid = 1'b0;
  logic [3:0] rec_cmd = '0;
  logic [31:0] rec_addr = '0;
  logic l1_ready = 1'b0, snp_ready = 1'b0, ctl_ready = 1'b0;

  logic rec_ready, l1_valid, snp_valid, ctl_valid, ctl_op, err_cmd;
  logic [1:0] l1_op, snp_op;
  logic [31:0] l1_addr, snp_addr, cnt_l1, cnt_snp, cnt_ctl, cnt_err;
  logic [3:0] fifo_count;

  logic s_rec_ready, s_l1_valid, s_snp_valid, s_ctl_valid, s_ctl_op, s_err_cmd;
  logic [1:0] s_l1_op, s_snp_op, s_cnt_l1, s_cnt_snp, s_cnt_ctl, s_cnt_err;
  logic [31:0] s_l1_addr, s_snp_addr;
  logic [3:0] s_fifo_count;

  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  trace_dispatcher #(.ADDR_WIDTH(32), .FIFO_DEPTH(8), .CNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_cmd(rec_cmd), .rec_addr(rec_addr),
    .l1_valid(l1_valid), .l1_ready(l1_ready), .l1_op(l1_op), .l1_addr(l1_addr),
    .snp_valid(snp_valid), .snp_ready(snp_ready), .snp_op(snp_op), .snp_addr(snp_addr),
    .ctl_valid(ctl_valid), .ctl_ready(ctl_ready), .ctl_op(ctl_op), .err_cmd(err_cmd),
    .fifo_count(fifo_count), .cnt_l1(cnt_l1), .cnt_snp(cnt_snp), .cnt_ctl(cnt_ctl), .cnt_err(cnt_err)
  );

  trace_dispatcher #(.ADDR_WIDTH(32), .FIFO_DEPTH(8), .CNT_WIDTH(2)) dut_sat (
    .clk(clk), .reset(reset), .rec_valid(rec_valid), .rec_ready(s_rec_ready),
    .rec_cmd(rec_cmd), .rec_addr(rec_addr),
    .l1_valid(s_l1_valid), .l1_ready(l1_ready), .l1_op(s_l1_op), .l1_addr(s_l1_addr),
    .snp_valid(s_snp_valid), .snp_ready(snp_ready), .snp_op(s_snp_op), .snp_addr(s_snp_addr),
    .ctl_valid(s_ctl_valid), .ctl_ready(ctl_ready), .ctl_op(s_ctl_op), .err_cmd(s_err_cmd),
    .fifo_count(s_fifo_count), .cnt_l1(s_cnt_l1), .cnt_snp(s_cnt_snp), .cnt_ctl(s_cnt_ctl), .cnt_err(s_cnt_err)
  );

  logic [213:0] obs;
  assign obs = {rec_ready, l1_valid, l1_op, l1_addr, snp_valid, snp_op, snp_addr, ctl_valid, ctl_op,
                err_cmd, fifo_count, cnt_l1, cnt_snp, cnt_ctl, cnt_err,
                s_cnt_l1, s_cnt_snp, s_cnt_ctl, s_cnt_err};

  // Reference model: a queue of pending records, one in-flight record, and plain counters.
  typedef struct packed { logic [3:0] cmd; logic [31:0] addr; } rec_t;
  rec_t mq[$];
  bit m_busy = 0, m_err = 0;
  int m_chan = 0;
  logic [1:0] m_op = '0;
  logic [31:0] m_addr = '0;
  longint m_cnt[4] = '{0, 0, 0, 0};
  int m_sat[4] = '{0, 0, 0, 0};
  bit m_push, m_hs, m_clr, m_ok;
  int m_ch;
  logic [1:0] m_nop;
  rec_t m_head;

  function automatic void decode(input logic [3:0] c, output bit ok, output int ch, output logic [1:0] op);
    ok = 1; ch = 0; op = 2'd0;
    if (c <= 4'd2) op = c[1:0];
    else if (c <= 4'd6) begin ch = 1; op = 2'(c - 4'd3); end
    else if (c == 4'd8 || c == 4'd9) begin ch = 2; op = {1'b0, c[0]}; end
    else ok = 0;
  endfunction

  function automatic void bump(input int i);
    if (m_cnt[i] < (longint'(1) << 32) - 1) m_cnt[i]++;
    if (m_sat[i] < 3) m_sat[i]++;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_busy = 0; m_err = 0; m_chan = 0; m_op = '0; m_addr = '0;
      for (int i = 0; i < 4; i++) begin m_cnt[i] = 0; m_sat[i] = 0; end
    end else begin
      m_push = rec_valid && (mq.size() < 8);
      m_hs = m_busy && ((m_chan == 0 && l1_ready) || (m_chan == 1 && snp_ready) || (m_chan == 2 && ctl_ready));
      m_clr = m_hs && m_chan == 2 && m_op == 2'd0;
      m_err = 0;
      if (m_hs) begin
        if (!m_clr) bump(m_chan);
        m_busy = 0;
      end
      if (!m_busy && mq.size() > 0) begin
        m_head = mq.pop_front();
        decode(m_head.cmd, m_ok, m_ch, m_nop);
        if (m_ok) begin m_busy = 1; m_chan = m_ch; m_op = m_nop; m_addr = m_head.addr; end
        else begin m_err = 1; if (!m_clr) bump(3); end
      end
      if (m_clr) for (int i = 0; i < 4; i++) begin m_cnt[i] = 0; m_sat[i] = 0; end
      if (m_push) mq.push_back({rec_cmd, rec_addr});
    end
  end

  function automatic logic [213:0] exp_vec();
    bit b0, b1, b2;
    b0 = m_busy && m_chan == 0;
    b1 = m_busy && m_chan == 1;
    b2 = m_busy && m_chan == 2;
    return {!reset && mq.size() < 8, b0, b0 ? m_op : 2'b0, b0 ? m_addr : 32'h0,
            b1, b1 ? m_op : 2'b0, b1 ? m_addr : 32'h0, b2, b2 ? m_op[0] : 1'b0,
            m_err, 4'(mq.size()), 32'(m_cnt[0]), 32'(m_cnt[1]), 32'(m_cnt[2]), 32'(m_cnt[3]),
            2'(m_sat[0]), 2'(m_sat[1]), 2'(m_sat[2]), 2'(m_sat[3])};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rec_valid = 0; l1_ready = 0; snp_ready = 0; ctl_ready = 0;
    reset = 1;
    step();
    reset = 0;
    step();
  endtask

  task automatic test_reset();
    step();
    n_tests++; if (obs !== '0) begin n_fail++; $display("FAIL reset_zero: got %h want 0", obs); end
    n_tests++; if (obs !== exp_vec()) begin n_fail++; $display("FAIL reset_vec: got %h want %h", obs, exp_vec()); end
    reset = 0;
    step();
    n_tests++; if (rec_ready !== 1'b1) begin n_fail++; $display("FAIL reset_rdy: got %b want 1", rec_ready); end
    n_tests++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", fifo_count); end
  endtask

  task automatic test_latency();
    do_reset();
    l1_ready = 1; snp_ready = 1; ctl_ready = 1;
    rec_valid = 1; rec_cmd = 4'd2; rec_addr = 32'h20;
    step();
    rec_valid = 0;
    n_tests++; if (fifo_count !== 4'd1 || l1_valid !== 1'b0) begin n_fail++; $display("FAIL lat_e0: got cnt=%0d vld=%b want cnt=1 vld=0", fifo_count, l1_valid); end
    step();
    n_tests++; if ({l1_valid, l1_op, l1_addr} !== {1'b1, 2'd2, 32'h20}) begin n_fail++; $display("FAIL lat_e1: got vld=%b op=%0d addr=%h want 1 2 20", l1_valid, l1_op, l1_addr); end
    step();
    n_tests++; if (l1_valid !== 1'b0 || cnt_l1 !== 32'd1) begin n_fail++; $display("FAIL lat_e2: got vld=%b cnt=%0d want 0 1", l1_valid, cnt_l1); end
    n_tests++; if (obs !== exp_vec()) begin n_fail++; $display("FAIL lat_vec: got %h want %h", obs, exp_vec()); end
  endtask

  task automatic test_decode();
    int cmds[9] = '{0, 1, 2, 3, 4, 5, 6, 8, 9};
    int chop[9] = '{0, 1, 2, 16, 17, 18, 19, 32, 33};
    int got_co[$];
    logic [31:0] got_addr[$];
    int idx = 0;
    bit acc, done = 0;
    do_reset();
    l1_ready = 1; snp_ready = 1; ctl_ready = 1;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      rec_valid = idx < 9;
      rec_cmd = 4'(cmds[idx % 9]);
      rec_addr = 32'h1000 + 32'(cmds[idx % 9]);
      acc = rec_valid && rec_ready;
      if (l1_valid) begin got_co.push_back(int'(l1_op)); got_addr.push_back(l1_addr); end
      if (snp_valid) begin got_co.push_back(16 + int'(snp_op)); got_addr.push_back(snp_addr); end
      if (ctl_valid) begin got_co.push_back(32 + int'(ctl_op)); got_addr.push_back(32'h1008 + 32'(ctl_op)); end
      step();
      if (acc) idx++;
      n_tests++; if (obs !== exp_vec()) begin n_fail++; $display("FAIL dec_vec cyc %0d: got %h want %h", cyc, obs, exp_vec()); end
      done = idx == 9 && mq.size() == 0 && !m_busy;
    end
    rec_valid = 0;
    n_tests++; if (got_co.size() != 9) begin n_fail++; $display("FAIL dec_issues: got %0d want 9", got_co.size()); end
    for (int i = 0; i < got_co.size() && i < 9; i++) begin
      n_tests++; if (got_co[i] != chop[i] || got_addr[i] !== 32'h1000 + 32'(cmds[i])) begin n_fail++; $display("FAIL dec_issue%0d: got chop=%0d addr=%h want %0d %h", i, got_co[i], got_addr[i], chop[i], 32'h1000 + 32'(cmds[i])); end
    end
    n_tests++; if ({cnt_l1, cnt_snp, cnt_ctl, cnt_err} !== {32'd0, 32'd0, 32'd1, 32'd0}) begin n_fail++; $display("FAIL dec_cnts: got %0d %0d %0d %0d want 0 0 1 0", cnt_l1, cnt_snp, cnt_ctl, cnt_err); end
    $display("[TB] decode sweep counters l1=%0d snp=%0d ctl=%0d", cnt_l1, cnt_snp, cnt_ctl);
  endtask

  task automatic test_backpressure();
    int k = 0;
    bit acc;
    do_reset();
    snp_ready = 1; ctl_ready = 1;
    for (int cyc = 0; cyc < 40 && k < 9; cyc++) begin
      rec_valid = 1; rec_cmd = 4'd0; rec_addr = 32'h200 + 32'(k);
      acc = rec_ready;
      step();
      if (acc) k++;
      n_tests++; if (obs !== exp_vec()) begin n_fail++; $display("FAIL bp_vec cyc %0d: got %h want %h", cyc, obs, exp_vec()); end
    end
    rec_valid = 0;
    n_tests++; if (k != 9) begin n_fail++; $display("FAIL bp_accept: got %0d want 9", k); end
    step();
    n_tests++; if ({fifo_count, rec_ready, l1_valid, l1_addr} !== {4'd8, 1'b0, 1'b1, 32'h200}) begin n_fail++; $display("FAIL bp_full: got cnt=%0d rdy=%b vld=%b addr=%h want 8 0 1 200", fifo_count, rec_ready, l1_valid, l1_addr); end
    l1_ready = 1;
    for (int j = 0; j < 9; j++) begin
      n_tests++; if (l1_valid !== 1'b1 || l1_addr !== 32'h200 + 32'(j)) begin n_fail++; $display("FAIL bp_drain%0d: got vld=%b addr=%h want 1 %h", j, l1_valid, l1_addr, 32'h200 + 32'(j)); end
      step();
    end
    n_tests++; if ({l1_valid, cnt_l1, fifo_count} !== {1'b0, 32'd9, 4'd0}) begin n_fail++; $display("FAIL bp_end: got vld=%b cnt=%0d occ=%0d want 0 9 0", l1_valid, cnt_l1, fifo_count); end
  endtask

  task automatic test_illegal();
    int errs = 0, snps = 0;
    do_reset();
    l1_ready = 1; snp_ready = 1; ctl_ready = 1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      rec_valid = cyc < 2;
      rec_cmd = (cyc == 0) ? 4'd7 : 4'd3;
      rec_addr = (cyc == 0) ? 32'h77 : 32'hABCD;
      step();
      if (err_cmd === 1'b1) errs++;
      if (snp_valid === 1'b1 && snp_op === 2'd0 && snp_addr === 32'hABCD) snps++;
      n_tests++; if (obs !== exp_vec()) begin n_fail++; $display("FAIL ill_vec cyc %0d: got %h want %h", cyc, obs, exp_vec()); end
    end
    n_tests++; if (errs != 1 || snps != 1) begin n_fail++; $display("FAIL ill_pulse: got err=%0d snp=%0d want 1 1", errs, snps); end
    n_tests++; if (cnt_err !== 32'd1 || cnt_snp !== 32'd1) begin n_fail++; $display("FAIL ill_cnt: got err=%0d snp=%0d want 1 1", cnt_err, cnt_snp); end
  endtask

  task automatic test_throughput();
    do_reset();
    l1_ready = 1;
    for (int c = 0; c < 15; c++) begin
      rec_valid = c < 12; rec_cmd = 4'd1; rec_addr = 32'(c);
      step();
      if (c >= 1 && c <= 12) begin
        n_tests++; if (l1_valid !== 1'b1) begin n_fail++; $display("FAIL tp_vld%0d: got %b want 1", c, l1_valid); end
      end
      if (c >= 2 && c <= 13) begin
        n_tests++; if (cnt_l1 !== 32'(c - 1)) begin n_fail++; $display("FAIL tp_cnt%0d: got %0d want %0d", c, cnt_l1, c - 1); end
      end
    end
    rec_valid = 0;
  endtask

  task automatic test_saturation();
    do_reset();
    l1_ready = 1; snp_ready = 1; ctl_ready = 1;
    for (int c = 0; c < 10; c++) begin
      rec_valid = c < 5; rec_cmd = 4'd4; rec_addr = 32'h40 + 32'(c);
      step();
    end
    rec_valid = 0;
    n_tests++; if (s_cnt_snp !== 2'd3 || cnt_snp !== 32'd5) begin n_fail++; $display("FAIL sat_cnt: got narrow=%0d wide=%0d want 3 5", s_cnt_snp, cnt_snp); end
    n_tests++; if (obs !== exp_vec()) begin n_fail++; $display("FAIL sat_vec: got %h want %h", obs, exp_vec()); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    l1_ready = 0;
    for (int c = 0; c < 3; c++) begin
      rec_valid = 1; rec_cmd = 4'd0; rec_addr = 32'h300 + 32'(c);
      step();
    end
    rec_valid = 0;
    #2 reset = 1;
    #1;
    n_tests++; if (obs !== '0) begin n_fail++; $display("FAIL rmid_zero: got %h want 0", obs); end
    n_tests++; if (obs !== exp_vec()) begin n_fail++; $display("FAIL rmid_vec: got %h want %h", obs, exp_vec()); end
    @(negedge clk);
    reset = 0;
    l1_ready = 1;
    step();
    n_tests++; if ({rec_ready, fifo_count, l1_valid} !== {1'b1, 4'd0, 1'b0}) begin n_fail++; $display("FAIL rmid_rel: got rdy=%b occ=%0d vld=%b want 1 0 0", rec_ready, fifo_count, l1_valid); end
    step();
    n_tests++; if (cnt_l1 !== 32'd0) begin n_fail++; $display("FAIL rmid_cnt: got %0d want 0", cnt_l1); end
  endtask

  task automatic test_random();
    int legal[9] = '{0, 1, 2, 3, 4, 5, 6, 8, 9};
    int r;
    do_reset();
    for (int cyc = 0; cyc < 500; cyc++) begin
      r = int'($urandom_range(0, 19));
      rec_valid = $urandom_range(0, 2) != 0;
      rec_cmd = (r < 17) ? 4'(legal[r % 9]) : ((r == 17) ? 4'd7 : 4'($urandom_range(10, 15)));
      rec_addr = $urandom;
      l1_ready = (cyc % 100 < 30) ? 1'b0 : ($urandom_range(0, 3) != 0);
      snp_ready = $urandom_range(0, 3) != 0;
      ctl_ready = $urandom_range(0, 1) != 0;
      step();
      n_tests++; if (obs !== exp_vec()) begin n_fail++; $display("FAIL rnd_vec cyc %0d: got %h want %h", cyc, obs, exp_vec()); end
    end
    rec_valid = 0;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_decode();
    test_backpressure();
    test_illegal();
    test_throughput();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
